vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen_if.sv | 25 ++
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Signals between the VGA timing generator, the pixel-colour lookup and the connector.
// The generator drives the master modport.
interface vga_timing_gen_if;
  logic [15:0] x;
  logic [15:0] y;
  logic [2:0]  rgb_in;
  logic        pix_en;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic        frame_start;

  modport master (
    output x, y, pix_en, vga_r, vga_g, vga_b, hsync, vsync, active, frame_start,
    input  rgb_in
  );

  modport slave (
    input  x, y, pix_en, vga_r, vga_g, vga_b, hsync, vsync, active, frame_start,
    output rgb_in
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-rate divider, h/v counters, clamped lookup coordinates,
// and one registered stage that keeps colour, blanking and sync aligned.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter bit SYNC_POL = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEG   = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEG   = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

  logic [15:0] div_cnt;
  logic [15:0] h_cnt;
  logic [15:0] v_cnt;
  logic        pix_en;

  logic        vis_p0;
  logic        hzone_p0;
  logic        vzone_p0;
  logic        origin_p0;

  logic [7:0]  r_p1;
  logic [7:0]  g_p1;
  logic [7:0]  b_p1;
  logic        act_p1;
  logic        hs_p1;
  logic        vs_p1;
  logic        fs_p1;

  function automatic logic [7:0] expand(input logic colour_bit, input logic vis);
    return vis ? {8{colour_bit}} : 8'h00;
  endfunction

  // With CLK_DIV=1 the divider sits at 0 and pix_en stays high.
  assign pix_en = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (pix_en) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 16'd0 : v_cnt + 16'd1;
      end else begin
        h_cnt <= h_cnt + 16'd1;
      end
    end
  end

  // Stage 0: decode the current counter position
  assign vis_p0    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hzone_p0  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vzone_p0  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign origin_p0 = (h_cnt == 16'd0) && (v_cnt == 16'd0);

  assign bus.x      = (h_cnt < H_ACT) ? h_cnt : 16'd0;
  assign bus.y      = (v_cnt < V_ACT) ? v_cnt : 16'd0;
  assign bus.pix_en = pix_en;

  // Stage 1: everything leaving the block is registered on the same pix_en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1   <= 8'h00;
      g_p1   <= 8'h00;
      b_p1   <= 8'h00;
      act_p1 <= 1'b0;
      hs_p1  <= ~SYNC_POL;
      vs_p1  <= ~SYNC_POL;
      fs_p1  <= 1'b0;
    end else begin
      fs_p1 <= pix_en && origin_p0;
      if (pix_en) begin
        r_p1   <= expand(bus.rgb_in[2], vis_p0);
        g_p1   <= expand(bus.rgb_in[1], vis_p0);
        b_p1   <= expand(bus.rgb_in[0], vis_p0);
        act_p1 <= vis_p0;
        hs_p1  <= hzone_p0 ? SYNC_POL : ~SYNC_POL;
        vs_p1  <= vzone_p0 ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

  assign bus.vga_r       = r_p1;
  assign bus.vga_g       = g_p1;
  assign bus.vga_b       = b_p1;
  assign bus.active      = act_p1;
  assign bus.hsync       = hs_p1;
  assign bus.vsync       = vs_p1;
  assign bus.frame_start = fs_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full 640x480 CLK_DIV=2 instance plus two reduced-geometry
// instances (CLK_DIV=2 and CLK_DIV=1) sharing one clock and reset.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        hs;
    logic        vs;
    logic        act;
    logic        fs;
    logic        pe;
  } sig_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   mode  = 0;
  int   seed  = 0;
  int   k;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Clock edges since reset release; outputs sampled at negedge reflect edge k.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  function automatic int c_cd(int i); return (i == 2) ? 1 : 2;   endfunction
  function automatic int c_ha(int i); return (i == 0) ? 640 : 16; endfunction
  function automatic int c_hf(int i); return (i == 0) ? 16 : 2;   endfunction
  function automatic int c_hs(int i); return (i == 0) ? 96 : 3;   endfunction
  function automatic int c_hb(int i); return (i == 0) ? 48 : 4;   endfunction
  function automatic int c_va(int i); return (i == 0) ? 480 : 8;  endfunction
  function automatic int c_vf(int i); return (i == 0) ? 10 : 2;   endfunction
  function automatic int c_vs(int i); return 2;                   endfunction
  function automatic int c_vb(int i); return (i == 0) ? 33 : 3;   endfunction
  function automatic int c_ht(int i); return c_ha(i) + c_hf(i) + c_hs(i) + c_hb(i); endfunction
  function automatic int c_vt(int i); return c_va(i) + c_vf(i) + c_vs(i) + c_vb(i); endfunction

  // Stand-in for the downstream colour lookup.
  function automatic logic [2:0] lookup(int md, int sd, logic [15:0] xx, logic [15:0] yy);
    int t;
    if (md == 0) return xx[2:0];
    if (md == 1) return sd[2:0];
    t = int'(xx) * 5 + int'(yy) * 3 + sd + (int'(xx) >> 3);
    return t[2:0];
  endfunction

  // Expected outputs after k edges, from elapsed pixel periods since release.
  function automatic sig_t model(int i, int kk);
    sig_t e;
    int cd = c_cd(i);
    int ht = c_ht(i);
    int fr = c_ht(i) * c_vt(i);
    int q  = kk / cd;
    int p, h, v, m, hm, vm;
    logic vis;
    logic [2:0] c;
    e    = '0;
    e.pe = ((kk % cd) == cd - 1);
    p = q % fr;
    h = p % ht;
    v = p / ht;
    e.x  = (h < c_ha(i)) ? 16'(h) : 16'd0;
    e.y  = (v < c_va(i)) ? 16'(v) : 16'd0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (q > 0) begin
      m  = (q - 1) % fr;
      hm = m % ht;
      vm = m / ht;
      vis   = (hm < c_ha(i)) && (vm < c_va(i));
      e.act = vis;
      c     = vis ? lookup(mode, seed, 16'(hm), 16'(vm)) : 3'b000;
      e.r   = {8{c[2]}};
      e.g   = {8{c[1]}};
      e.b   = {8{c[0]}};
      e.hs  = !((hm >= c_ha(i) + c_hf(i)) && (hm < c_ha(i) + c_hf(i) + c_hs(i)));
      e.vs  = !((vm >= c_va(i) + c_vf(i)) && (vm < c_va(i) + c_vf(i) + c_vs(i)));
      e.fs  = ((kk % cd) == 0) && (m == 0);
    end
    return e;
  endfunction

  vga_timing_gen_if if0 ();
  vga_timing_gen_if if1 ();
  vga_timing_gen_if if2 ();

  assign if0.rgb_in = lookup(mode, seed, if0.x, if0.y);
  assign if1.rgb_in = lookup(mode, seed, if1.x, if1.y);
  assign if2.rgb_in = lookup(mode, seed, if2.x, if2.y);

  vga_timing_gen #(.CLK_DIV(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CLK_DIV(2),   .SYNC_POL(1'b0)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CLK_DIV(1),   .SYNC_POL(1'b0)
  ) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  sig_t obs [3];
  assign obs[0] = {if0.x, if0.y, if0.vga_r, if0.vga_g, if0.vga_b,
                   if0.hsync, if0.vsync, if0.active, if0.frame_start, if0.pix_en};
  assign obs[1] = {if1.x, if1.y, if1.vga_r, if1.vga_g, if1.vga_b,
                   if1.hsync, if1.vsync, if1.active, if1.frame_start, if1.pix_en};
  assign obs[2] = {if2.x, if2.y, if2.vga_r, if2.vga_g, if2.vga_b,
                   if2.hsync, if2.vsync, if2.active, if2.frame_start, if2.pix_en};

  task automatic apply_reset(int md, int sd);
    @(negedge clk);
    rst_n = 1'b0;
    mode  = md;
    seed  = sd;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    sig_t e;
    int first_fs [3];
    @(negedge clk);
    rst_n = 1'b0;
    mode  = 0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      e = '0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      e.pe = (i == 2);
      checks++;
      if (obs[i] !== e) begin
        failures++;
        $display("FAIL reset_values dut%0d got=%h want=%h", i, obs[i], e);
      end
      first_fs[i] = -1;
    end
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (obs[i].fs && first_fs[i] < 0) first_fs[i] = k;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (first_fs[i] !== c_cd(i)) begin
        failures++;
        $display("FAIL first_frame_start dut%0d got_clk=%0d want_clk=%0d", i, first_fs[i], c_cd(i));
      end
    end
  endtask

  task automatic test_line_timing;
    int t_fall[$];
    int low_len[$];
    int act_len[$];
    int act_rise[$];
    int lo_st = -1;
    int ac_st = -1;
    logic p_hs = 1'b1;
    logic p_ac = 1'b0;
    apply_reset(0, 0);
    for (int n = 0; n < 3 * 1600 + 100; n++) begin
      @(negedge clk);
      if (p_hs && !obs[0].hs) begin t_fall.push_back(k); lo_st = k; end
      if (!p_hs && obs[0].hs && lo_st >= 0) low_len.push_back(k - lo_st);
      if (!p_ac && obs[0].act) begin act_rise.push_back(k); ac_st = k; end
      if (p_ac && !obs[0].act && ac_st >= 0) act_len.push_back(k - ac_st);
      p_hs = obs[0].hs;
      p_ac = obs[0].act;
    end
    checks++;
    if (low_len.size() < 2 || act_len.size() < 2 || t_fall.size() < 2 || act_rise.size() < 1) begin
      failures++;
      $display("FAIL line_edges_seen got=%0d/%0d want>=2", low_len.size(), act_len.size());
    end else begin
      checks++;
      if (t_fall[0] !== 1314) begin
        failures++;
        $display("FAIL hsync_first_fall got_clk=%0d want_clk=%0d", t_fall[0], 1314);
      end
      checks++;
      if (act_rise[0] !== 2) begin
        failures++;
        $display("FAIL active_first_rise got_clk=%0d want_clk=%0d", act_rise[0], 2);
      end
    end
    foreach (low_len[j]) begin
      checks++;
      if (low_len[j] !== 192) begin
        failures++;
        $display("FAIL hsync_low_width[%0d] got=%0d want=%0d", j, low_len[j], 192);
      end
    end
    for (int j = 1; j < t_fall.size(); j++) begin
      checks++;
      if (t_fall[j] - t_fall[j-1] !== 1600) begin
        failures++;
        $display("FAIL hsync_period[%0d] got=%0d want=%0d", j, t_fall[j] - t_fall[j-1], 1600);
      end
    end
    foreach (act_len[j]) begin
      checks++;
      if (act_len[j] !== 1280) begin
        failures++;
        $display("FAIL active_run[%0d] got=%0d want=%0d", j, act_len[j], 1280);
      end
    end
  endtask

  task automatic test_frame_timing;
    int fs_t [3][$];
    int vs_len [3][$];
    int lines [3][$];
    int vs_st [3];
    int lcnt [3];
    logic pvs [3];
    logic pac [3];
    int want;
    for (int i = 0; i < 3; i++) begin
      vs_st[i] = -1; lcnt[i] = 0; pvs[i] = 1'b1; pac[i] = 1'b0;
    end
    apply_reset(0, 0);
    for (int n = 0; n < 3 * 750 + 20; n++) begin
      @(negedge clk);
      for (int i = 1; i < 3; i++) begin
        if (obs[i].fs) begin
          if (fs_t[i].size() > 0) lines[i].push_back(lcnt[i]);
          lcnt[i] = 0;
          fs_t[i].push_back(k);
        end
        if (!pac[i] && obs[i].act) lcnt[i]++;
        if (pvs[i] && !obs[i].vs) vs_st[i] = k;
        if (!pvs[i] && obs[i].vs && vs_st[i] >= 0) vs_len[i].push_back(k - vs_st[i]);
        pvs[i] = obs[i].vs;
        pac[i] = obs[i].act;
      end
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (fs_t[i].size() < 3 || vs_len[i].size() < 2) begin
        failures++;
        $display("FAIL frame_events dut%0d got=%0d/%0d want>=3/2", i, fs_t[i].size(), vs_len[i].size());
      end
      want = c_ht(i) * c_vt(i) * c_cd(i);
      for (int j = 1; j < fs_t[i].size(); j++) begin
        checks++;
        if (fs_t[i][j] - fs_t[i][j-1] !== want) begin
          failures++;
          $display("FAIL frame_period dut%0d[%0d] got=%0d want=%0d", i, j, fs_t[i][j] - fs_t[i][j-1], want);
        end
      end
      want = c_vs(i) * c_ht(i) * c_cd(i);
      foreach (vs_len[i][j]) begin
        checks++;
        if (vs_len[i][j] !== want) begin
          failures++;
          $display("FAIL vsync_width dut%0d[%0d] got=%0d want=%0d", i, j, vs_len[i][j], want);
        end
      end
      foreach (lines[i][j]) begin
        checks++;
        if (lines[i][j] !== c_va(i)) begin
          failures++;
          $display("FAIL active_lines dut%0d[%0d] got=%0d want=%0d", i, j, lines[i][j], c_va(i));
        end
      end
    end
  endtask

  task automatic test_blanking;
    logic [2:0]  cv;
    logic [23:0] want;
    int act_seen;
    for (int t = 0; t < 2; t++) begin
      cv = (t == 0) ? 3'b111 : 3'b100;
      act_seen = 0;
      apply_reset(1, int'(cv));
      for (int n = 0; n < 1700; n++) begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          want = obs[i].act ? {{8{cv[2]}}, {8{cv[1]}}, {8{cv[0]}}} : 24'h000000;
          if (obs[i].act) act_seen++;
          checks++;
          if ({obs[i].r, obs[i].g, obs[i].b} !== want) begin
            failures++;
            $display("FAIL blanking dut%0d rgb=%0b clk=%0d got=%h want=%h", i, cv, k,
                     {obs[i].r, obs[i].g, obs[i].b}, want);
          end
        end
      end
      checks++;
      if (act_seen < 1280) begin
        failures++;
        $display("FAIL blanking_active_seen got=%0d want>=%0d", act_seen, 1280);
      end
    end
  endtask

  task automatic test_alignment;
    sig_t e;
    for (int t = 0; t < 2; t++) begin
      apply_reset((t == 0) ? 0 : 2, int'($urandom));
      for (int n = 0; n < ((t == 0) ? 1700 : 3300); n++) begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          e = model(i, k);
          checks++;
          if (obs[i] !== e) begin
            failures++;
            $display("FAIL align dut%0d mode=%0d clk=%0d got=%h want=%h", i, mode, k, obs[i], e);
          end
          checks++;
          if (obs[i].x >= 16'(c_ha(i)) || obs[i].y >= 16'(c_va(i))) begin
            failures++;
            $display("FAIL coord_range dut%0d got=%0d,%0d want<%0d,%0d", i, obs[i].x, obs[i].y, c_ha(i), c_va(i));
          end
        end
      end
    end
  endtask

  task automatic test_mid_frame_reset;
    sig_t e;
    int found = 0;
    apply_reset(2, int'($urandom));
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (obs[0].x == 16'd300 && obs[0].y == 16'd1) begin found = 1; break; end
    end
    checks++;
    if (found == 0) begin
      failures++;
      $display("FAIL midframe_reach got=%0d want=%0d", found, 1);
    end
    checks++;
    if (obs[0].act !== 1'b1) begin
      failures++;
      $display("FAIL midframe_pre_active got=%b want=%b", obs[0].act, 1'b1);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      e = '0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      e.pe = (i == 2);
      checks++;
      if (obs[i] !== e) begin
        failures++;
        $display("FAIL midframe_async_reset dut%0d got=%h want=%h", i, obs[i], e);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 1800; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        e = model(i, k);
        checks++;
        if (obs[i] !== e) begin
          failures++;
          $display("FAIL restart dut%0d clk=%0d got=%h want=%h", i, k, obs[i], e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_blanking();
    test_alignment();
    test_mid_frame_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
